// File: rtl/riscv_pkg.sv
// Shared RV32I pipeline constants.
//   XLEN              datapath / address width
//   NOP_INSTR         canonical NOP (addi x0, x0, 0) used to fill empty IF/ID slots
//   RESET_PC_DEFAULT  default first fetch address after reset
package riscv_pkg;
    localparam int          XLEN             = 32;
    localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
endpackage

// File: rtl/fetch_stage_if.sv
// Instruction-memory channel between the fetch stage and imem.
//   imem_req_valid / imem_req_ready / imem_req_addr : request handshake
//   imem_rsp_valid / imem_rsp_data                  : in-order responses, always accepted
// master = fetch stage, slave = instruction memory.
interface fetch_stage_if #(
    parameter int XLEN = riscv_pkg::XLEN
) ();
    logic            imem_req_valid;
    logic            imem_req_ready;
    logic [XLEN-1:0] imem_req_addr;
    logic            imem_rsp_valid;
    logic [XLEN-1:0] imem_rsp_data;

    modport master (
        output imem_req_valid,
        output imem_req_addr,
        input  imem_req_ready,
        input  imem_rsp_valid,
        input  imem_rsp_data
    );

    modport slave (
        input  imem_req_valid,
        input  imem_req_addr,
        output imem_req_ready,
        output imem_rsp_valid,
        output imem_rsp_data
    );
endinterface

// File: rtl/fetch_queue.sv
// Small synchronous FIFO with push/pop/clear and occupancy count.
//   clk, rst_n : clock, async active-low reset
//   i_push     : write i_data at tail
//   i_pop      : drop head (ignored when empty)
//   i_clear    : empty the FIFO, dominates push/pop
//   o_data     : head entry
//   o_count    : number of valid entries (0..DEPTH)
// The caller guarantees no push while full; DEPTH must be a power of 2
// so the pointers wrap naturally.
module fetch_queue #(
    parameter  int DEPTH = 2,
    parameter  int WIDTH = 32,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = AW + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_push,
    input  logic             i_pop,
    input  logic             i_clear,
    input  logic [WIDTH-1:0] i_data,
    output logic [WIDTH-1:0] o_data,
    output logic [CW-1:0]    o_count
);
    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wptr;
    logic [AW-1:0]    r_rptr;
    logic [CW-1:0]    r_count;
    logic             w_pop;

    assign w_pop   = i_pop && (r_count != '0);
    assign o_data  = r_mem[r_rptr];
    assign o_count = r_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else if (i_clear) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (i_push) r_wptr <= r_wptr + 1'b1;
            if (w_pop)  r_rptr <= r_rptr + 1'b1;
            r_count <= r_count + CW'(i_push) - CW'(w_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (i_push && !i_clear) r_mem[r_wptr] <= i_data;
    end
endmodule

// File: rtl/fetch_stage.sv
// RV32I IF stage: owns PC_F, issues imem requests under a credit rule,
// buffers responses and drives the IF/ID register with stall and flush.
//   clk, rst_n          : clock, async active-low reset
//   imem (master)       : instruction-memory request/response channel
//   Stall_D             : hold IF/ID
//   PCSrc_E, PCTarget_E : execute-stage redirect (wins over stall)
//   Instr_D, PC_D, PCPlus4_D, Valid_D : IF/ID register
module fetch_stage #(
    parameter int              XLEN     = riscv_pkg::XLEN,
    parameter logic [XLEN-1:0] RESET_PC = XLEN'(riscv_pkg::RESET_PC_DEFAULT),
    parameter int              QDEPTH   = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    fetch_stage_if.master    imem,
    input  logic             Stall_D,
    input  logic             PCSrc_E,
    input  logic [XLEN-1:0]  PCTarget_E,
    output logic [XLEN-1:0]  Instr_D,
    output logic [XLEN-1:0]  PC_D,
    output logic [XLEN-1:0]  PCPlus4_D,
    output logic             Valid_D
);
    import riscv_pkg::NOP_INSTR;

    localparam int              CW  = $clog2(QDEPTH) + 1;
    localparam logic [XLEN-1:0] NOP = XLEN'(NOP_INSTR);

    logic [XLEN-1:0]   r_pc_f;
    logic [CW-1:0]     r_drop_cnt;
    logic [CW-1:0]     w_iq_count;
    logic [CW-1:0]     w_tq_count;
    logic [XLEN-1:0]   w_tag_head;
    logic [2*XLEN-1:0] w_iq_head;
    logic [CW:0]       w_inflight;
    logic              w_pop;
    logic              w_push;
    logic              w_rsp;
    logic              w_accept;

    // The tag queue holds exactly one entry per in-flight request, so its
    // occupancy doubles as the outstanding-request counter.
    assign w_rsp      = imem.imem_rsp_valid;
    assign w_pop      = !Stall_D && (w_iq_count != '0);
    assign w_push     = w_rsp && (r_drop_cnt == '0) && !PCSrc_E;
    assign w_inflight = {1'b0, w_iq_count} + {1'b0, w_tq_count} - (CW+1)'(w_pop);

    // Credit rule: queued + outstanding never exceeds QDEPTH, so every
    // response has a slot waiting for it.
    assign imem.imem_req_valid = rst_n && !PCSrc_E && (w_inflight < (CW+1)'(QDEPTH));
    assign imem.imem_req_addr  = r_pc_f;
    assign w_accept            = imem.imem_req_valid && imem.imem_req_ready;

    fetch_queue #(.DEPTH(QDEPTH), .WIDTH(XLEN)) u_tq (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_accept),
        .i_pop   (w_rsp),
        .i_clear (1'b0),
        .i_data  (r_pc_f),
        .o_data  (w_tag_head),
        .o_count (w_tq_count)
    );

    fetch_queue #(.DEPTH(QDEPTH), .WIDTH(2*XLEN)) u_iq (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_clear (PCSrc_E),
        .i_data  ({w_tag_head, imem.imem_rsp_data}),
        .o_data  (w_iq_head),
        .o_count (w_iq_count)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc_f     <= RESET_PC;
            r_drop_cnt <= '0;
        end else begin
            if (PCSrc_E)       r_pc_f <= PCTarget_E;
            else if (w_accept) r_pc_f <= r_pc_f + XLEN'(4);

            // On redirect every request still in flight is stale, except the
            // one answering this very cycle, which is discarded right here.
            if (PCSrc_E)
                r_drop_cnt <= w_tq_count - CW'(w_rsp);
            else if (w_rsp && (r_drop_cnt != '0))
                r_drop_cnt <= r_drop_cnt - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            Valid_D   <= 1'b0;
            Instr_D   <= NOP;
            PC_D      <= '0;
            PCPlus4_D <= '0;
        end else if (PCSrc_E) begin
            Valid_D <= 1'b0;
            Instr_D <= NOP;
        end else if (!Stall_D) begin
            if (w_iq_count != '0) begin
                Valid_D   <= 1'b1;
                Instr_D   <= w_iq_head[XLEN-1:0];
                PC_D      <= w_iq_head[2*XLEN-1:XLEN];
                PCPlus4_D <= w_iq_head[2*XLEN-1:XLEN] + XLEN'(4);
            end else begin
                Valid_D <= 1'b0;
                Instr_D <= NOP;
            end
        end
    end
endmodule

// File: tb/tb_fetch_stage.sv
module tb_fetch_stage;
    localparam int          QD  = 2;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        Stall_D = 1'b0;
    logic        PCSrc_E = 1'b0;
    logic [31:0] PCTarget_E = '0;
    logic [31:0] Instr_D, PC_D, PCPlus4_D;
    logic        Valid_D;

    always #5 clk = ~clk;

    fetch_stage_if #(.XLEN(32)) imem_if ();

    fetch_stage #(.XLEN(32), .RESET_PC(32'h0), .QDEPTH(QD)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .imem       (imem_if),
        .Stall_D    (Stall_D),
        .PCSrc_E    (PCSrc_E),
        .PCTarget_E (PCTarget_E),
        .Instr_D    (Instr_D),
        .PC_D       (PC_D),
        .PCPlus4_D  (PCPlus4_D),
        .Valid_D    (Valid_D)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: actual=%h expected=%h", nm, act, exp);
        end
    endtask

    task automatic fail_now(input string nm);
        total++;
        bad++;
        $display("FAIL %s: bound expired", nm);
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {~a[15:0], a[15:0]};
    endfunction

    // ---------------- imem model: in-order, latency 1..4 ----------------
    typedef struct { logic [31:0] addr; int due; } pend_t;
    pend_t       pend[$];
    int          cyc = 0;
    int          last_due = 0;
    int          lat_fix = 1;
    int          lat_now;
    int          due_now;
    int          first_acc = -1;
    bit          rdy_low = 0;
    bit          rdy_rand = 0;
    bit          hold_prev = 0;
    bit          redir_prev_m = 0;
    logic [31:0] addr_prev;

    initial begin
        imem_if.imem_req_ready = 1'b1;
        imem_if.imem_rsp_valid = 1'b0;
        imem_if.imem_rsp_data  = '0;
        forever begin
            @(posedge clk);
            cyc++;
            #1;
            if (pend.size() > 0 && pend[0].due <= cyc) begin
                imem_if.imem_rsp_valid = 1'b1;
                imem_if.imem_rsp_data  = mem_word(pend[0].addr);
                void'(pend.pop_front());
            end else begin
                imem_if.imem_rsp_valid = 1'b0;
                imem_if.imem_rsp_data  = '0;
            end
            imem_if.imem_req_ready = rdy_low ? 1'b0 :
                                     (rdy_rand ? ($urandom_range(0, 4) != 0) : 1'b1);
            @(negedge clk);
            if (!rst_n) begin
                pend.delete();
                last_due  = 0;
                hold_prev = 0;
                redir_prev_m = 0;
            end else begin
                if (hold_prev && !redir_prev_m)
                    check("addr_hold", imem_if.imem_req_addr, addr_prev);
                if (imem_if.imem_req_valid && imem_if.imem_req_ready) begin
                    lat_now = (lat_fix > 0) ? lat_fix : int'($urandom_range(1, 4));
                    due_now = cyc + lat_now;
                    if (due_now <= last_due) due_now = last_due + 1;
                    last_due = due_now;
                    pend.push_back('{imem_if.imem_req_addr, due_now});
                    if (first_acc < 0) first_acc = cyc + 1;
                end
                check("outstanding_le_q", 32'(pend.size() <= QD), 32'd1);
                check("iq_count_le_q", 32'(int'(dut.w_iq_count) <= QD), 32'd1);
                hold_prev    = imem_if.imem_req_valid && !imem_if.imem_req_ready;
                addr_prev    = imem_if.imem_req_addr;
                redir_prev_m = PCSrc_E;
            end
        end
    end

    // ---------------- scoreboard monitor on IF/ID ----------------
    logic [31:0] tgt_q[$];
    logic [31:0] exp_pc = '0;
    logic [31:0] m_pc = '0;
    bit          m_valid = 0;
    bit          m_stall_prev = 0;
    bit          m_redir_prev = 0;
    int          first_val = -1;

    initial begin
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                check("rst_valid", 32'(Valid_D), 32'd0);
                check("rst_instr", Instr_D, NOP);
                check("rst_pc", PC_D, 32'h0);
                check("rst_pc4", PCPlus4_D, 32'h0);
                while (tgt_q.size() > 0) exp_pc = tgt_q.pop_front();
                m_valid = 0;
                m_stall_prev = 0;
                m_redir_prev = 0;
            end else begin
                if (m_redir_prev) begin
                    check("flush_valid", 32'(Valid_D), 32'd0);
                    check("flush_instr", Instr_D, NOP);
                    m_valid = 0;
                    if (tgt_q.size() > 0) exp_pc = tgt_q.pop_front();
                    else fail_now("target_queue_empty");
                end else if (m_stall_prev) begin
                    check("hold_valid", 32'(Valid_D), 32'(m_valid));
                    if (m_valid) begin
                        check("hold_pc", PC_D, m_pc);
                        check("hold_instr", Instr_D, mem_word(m_pc));
                        check("hold_pc4", PCPlus4_D, m_pc + 32'd4);
                    end
                end else if (Valid_D) begin
                    if (first_val < 0) first_val = cyc;
                    check("seq_pc", PC_D, exp_pc);
                    check("seq_instr", Instr_D, mem_word(exp_pc));
                    check("seq_pc4", PCPlus4_D, exp_pc + 32'd4);
                    m_pc    = exp_pc;
                    exp_pc  = exp_pc + 32'd4;
                    m_valid = 1;
                end else begin
                    check("empty_instr", Instr_D, NOP);
                    m_valid = 0;
                end
                m_stall_prev = Stall_D;
                m_redir_prev = PCSrc_E;
            end
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic redirect(input logic [31:0] t);
        PCSrc_E    = 1'b1;
        PCTarget_E = t;
        tgt_q.push_back(t);
        step();
        PCSrc_E = 1'b0;
    endtask

    bit          found;
    logic [31:0] rt;

    initial begin
        tgt_q.push_back(32'h0);
        rst_n = 1'b0;
        run(3);
        check("rst_req_valid", 32'(imem_if.imem_req_valid), 32'd0);
        rst_n = 1'b1;

        // streaming from reset, 1-cycle imem
        run(4);
        check("first_latency", 32'(first_val - first_acc), 32'd2);

        // stall at PC_D=8
        found = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            step();
            if (Valid_D && PC_D == 32'h8) found = 1;
        end
        if (!found) fail_now("wait_pc8");
        Stall_D = 1'b1;
        #1;
        check("stall_credit_block", 32'(imem_if.imem_req_valid), 32'd0);
        for (int i = 0; i < 3; i++) begin
            step();
            check("stall_pc", PC_D, 32'h8);
            check("stall_instr", Instr_D, mem_word(32'h8));
        end
        Stall_D = 1'b0;
        step();
        check("release_valid", 32'(Valid_D), 32'd1);
        check("release_pc", PC_D, 32'hC);

        // redirect with two outstanding and a response landing the same cycle
        lat_fix = 2;
        found = 0;
        for (int i = 0; i < 30 && !found; i++) begin
            step();
            if (dut.w_tq_count == 2'd2 && imem_if.imem_rsp_valid) found = 1;
        end
        if (!found) fail_now("wait_two_outstanding");
        redirect(32'h100);
        check("redir_valid", 32'(Valid_D), 32'd0);
        check("redir_instr", Instr_D, NOP);
        check("redir_drop_cnt", 32'(dut.r_drop_cnt), 32'd1);
        found = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            if (Valid_D) found = 1;
            else step();
        end
        if (!found) fail_now("wait_redir_valid");
        check("redir_first_pc", PC_D, 32'h100);
        check("redir_first_instr", Instr_D, mem_word(32'h100));
        run(4);

        // flush wins over stall
        Stall_D = 1'b1;
        redirect(32'h200);
        Stall_D = 1'b0;
        check("flush_over_stall_valid", 32'(Valid_D), 32'd0);
        check("flush_over_stall_instr", Instr_D, NOP);
        run(8);

        // imem back-pressure
        rdy_low = 1;
        run(6);
        check("drain_valid", 32'(Valid_D), 32'd0);
        rdy_low = 0;
        run(10);

        // PC wrap and misaligned target passthrough
        lat_fix = 1;
        redirect(32'hFFFF_FFF8);
        run(10);
        redirect(32'h0000_0102);
        run(6);

        // random latency, stalls, redirects, ready
        lat_fix  = 0;
        rdy_rand = 1;
        for (int i = 0; i < 400; i++) begin
            Stall_D = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 24) == 0) begin
                rt = $urandom & 32'hFFFF_FFFC;
                PCSrc_E    = 1'b1;
                PCTarget_E = rt;
                tgt_q.push_back(rt);
            end else begin
                PCSrc_E = 1'b0;
            end
            step();
        end
        PCSrc_E  = 1'b0;
        Stall_D  = 1'b0;
        rdy_rand = 0;
        lat_fix  = 3;
        run(6);

        // reset in the middle of traffic
        tgt_q.push_back(32'h0);
        rst_n = 1'b0;
        #1;
        check("async_rst_valid", 32'(Valid_D), 32'd0);
        check("async_rst_req", 32'(imem_if.imem_req_valid), 32'd0);
        run(2);
        rst_n   = 1'b1;
        lat_fix = 1;
        run(12);
        check("post_rst_valid", 32'(Valid_D), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
IF stage of the 5-stage RV32I pipeline; produces the Instr_D/PC_D/PCPlus4_D fields that the decode-stage control unit and register file consume.
- Owns PC_F and issues requests to instruction memory over a valid/ready channel with variable response latency.
- Buffers responses in a small queue; drives the IF/ID pipeline register with stall and redirect (branch/jump flush) support.

Parameters:
XLEN, 32, datapath and address width
RESET_PC, 32'h0000_0000, first fetch address after reset
QDEPTH, 2, instruction queue entries and max outstanding requests (power of 2, >=2)

Ports:
clk  in  1  clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
imem_req_valid  out  1  fetch request valid
imem_req_ready  in  1  imem accepts request
imem_req_addr  out  XLEN  fetch address (= PC_F)
imem_rsp_valid  in  1  response valid, in request order, always accepted
imem_rsp_data  in  XLEN  instruction word
Stall_D  in  1  hazard unit: hold IF/ID register
PCSrc_E  in  1  execute-stage redirect (taken branch/jump)
PCTarget_E  in  XLEN  redirect target
Instr_D  out  XLEN  IF/ID instruction
PC_D  out  XLEN  IF/ID PC
PCPlus4_D  out  XLEN  IF/ID PC+4
Valid_D  out  1  IF/ID holds a real instruction

Behaviour:
- Reset (async, rst_n=0): PC_F=RESET_PC, Valid_D=0, Instr_D=32'h0000_0013 (NOP), PC_D=0, PCPlus4_D=0, queue empty, outstanding=0, drop_cnt=0. imem_req_valid=0 during reset; reset mid-transaction discards everything in flight, imem side resets concurrently.
- pop = !Stall_D && count>0. push = imem_rsp_valid && drop_cnt==0 && !PCSrc_E.
- Issue: imem_req_valid = !PCSrc_E && (count + outstanding - pop) < QDEPTH. Accept = valid && ready -> PC_F += 4, outstanding += 1; issued address pushed into a PC tag queue (QDEPTH entries).
- PC_F changes only on accept or redirect; imem_req_addr stable while valid && !ready, except a redirect may withdraw the request (imem tolerates withdrawal).
- Response with drop_cnt==0: {tag-queue head, data} written to instruction queue, tag popped, outstanding -= 1. With drop_cnt>0: discarded, drop_cnt -= 1, outstanding -= 1, tag popped.
- IF/ID: if !Stall_D, load queue head -> Instr_D/PC_D, PCPlus4_D=PC_D+4, Valid_D=1; if queue empty, Valid_D=0 and Instr_D=NOP. If Stall_D, hold all.
- Min latency: req accepted cycle N, rsp cycle N+1, Valid_D high from cycle N+2. Sustained 1 instr/cycle with 1-cycle imem and QDEPTH=2.
- Redirect (PCSrc_E=1), highest priority, overrides Stall_D: PC_F<=PCTarget_E; instruction queue cleared; Valid_D<=0, Instr_D<=NOP; no request issued this cycle; drop_cnt<=outstanding - (imem_rsp_valid ? 1 : 0) (the response arriving this cycle is discarded); the tag queue keeps the entries of the in-flight requests.
- Fetch resumes from PCTarget_E next cycle; its responses are never confused with stale ones (drop_cnt counts out stale responses, which arrive in order).
- Simultaneous push and pop: allowed; count unchanged. Queue never overflows (credit rule). Pointers wrap modulo QDEPTH.
- PC arithmetic modulo 2^XLEN (wraps at 32'hFFFF_FFFC -> 0). Misaligned PCTarget_E passed through unchanged (alignment checked elsewhere).

Decomposition:
- Shared package riscv_pkg: XLEN, NOP_INSTR=32'h0000_0013, RESET_PC default.
- One sub-module: fetch_queue, synchronous FIFO (QDEPTH x width) with push/pop/clear, count, async active-low reset; instantiated twice (PC tag queue width XLEN, instruction queue width 2*XLEN).

Test Plan:
- Reset then imem ready=1, 1-cycle response -> Valid_D first high 2 cycles after first accept, PC_D=0,4,8,... every cycle, PCPlus4_D=PC_D+4.
- Stall_D held 3 cycles at PC_D=8 -> PC_D/Instr_D stable at 8, imem_req_valid drops once queue+outstanding=2, then PC_D=12 the cycle after release with no gaps or duplicates.
- PCSrc_E=1, PCTarget_E=0x100, with 2 requests outstanding and a response the same cycle -> Valid_D=0 next cycle, both stale responses discarded, next valid PC_D=0x100 with the matching instruction.
- PCSrc_E and Stall_D both high -> flush wins: Valid_D=0, Instr_D=NOP.
- imem_req_ready=0 for 5 cycles -> imem_req_addr held constant, Valid_D=0 after queue drains, resumes in order on ready.
- Random response latency 1-4 cycles, random stalls and redirects vs. reference model -> PC_D sequence and Instr_D-to-PC_D pairing exact; count never exceeds QDEPTH.
